// File: rtl/preload_pkg.sv
// Shared definitions for the RAM preloader: FSM state encoding and memory access-size codes.
// Pure declarations, no latency or flow control of its own.
// Build option PRELOAD_CHECKSUM_EN enables the checksum state used by ram_preload_ctrl.
package preload_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_COLLECT  = 3'd1,
    ST_WRITE    = 3'd2,
    ST_WAIT_MFC = 3'd3,
    ST_CHECK    = 3'd4,
    ST_DONE     = 3'd5,
    ST_ERROR    = 3'd6
  } state_t;

  localparam logic [1:0] MT_BYTE = 2'd0;
  localparam logic [1:0] MT_HALF = 2'd1;
  localparam logic [1:0] MT_WORD = 2'd2;

  function automatic logic [1:0] bpw_to_type(input int bpw);
    case (bpw)
      1:       return MT_BYTE;
      2:       return MT_HALF;
      default: return MT_WORD;
    endcase
  endfunction

endpackage

// File: rtl/preload_word_asm.sv
// Big-endian word assembler: bytes shift in from the LSB side, a final partial word is zero-padded.
// Latency: word register updates on the clock edge that accepts a byte.
// Backpressure: none internally; the controller only strobes byte_vld when it can take the byte.
module preload_word_asm
  import preload_pkg::*;
#(
  parameter int BPW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             next_word,
  input  logic             byte_vld,
  input  logic [7:0]       byte_dat,
  input  logic             byte_last,
  output logic [8*BPW-1:0] word_dat,
  output logic             word_full
);

  logic [2:0]       fill_q;
  logic [8*BPW-1:0] shifted;
  logic [8*BPW-1:0] padded;

  generate
    if (BPW == 1) begin : g_single
      assign shifted = byte_dat;
    end else begin : g_multi
      assign shifted = {word_dat[8*BPW-9:0], byte_dat};
    end
  endgenerate

  // Left-justify a short final word; stale bytes from the previous word fall off the top.
  assign padded    = shifted << (8 * (BPW - 1 - int'(fill_q)));
  assign word_full = (fill_q == 3'(BPW - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      word_dat <= '0;
      fill_q   <= '0;
    end else if (clear) begin
      word_dat <= '0;
      fill_q   <= '0;
    end else if (byte_vld) begin
      word_dat <= byte_last ? padded : shifted;
      fill_q   <= fill_q + 3'd1;
    end else if (next_word) begin
      fill_q   <= '0;
    end
  end

endmodule

// File: rtl/ram_preload_ctrl.sv
// RAM preloader: streams bytes into big-endian words, writes them via Mov/MFC, holds the CPU until done.
// Latency: last byte of a word -> Mem_Mov in 2 cycles; Mem_MFC -> Done or next In_Ready in 1 cycle.
// Backpressure: In_Ready only while collecting; define PRELOAD_CHECKSUM_EN for a trailing checksum byte.
module ram_preload_ctrl
  import preload_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int BPW         = 4,
  parameter int BASE_ADDR   = 0,
  parameter int DEPTH       = 512,
  parameter int MFC_TIMEOUT = 64
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              Start,
  input  logic              In_Valid,
  input  logic [7:0]        In_Data,
  input  logic              In_Last,
  output logic              In_Ready,
  output logic              Mem_Mov,
  output logic              Mem_RW,
  output logic [1:0]        Mem_Type,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [8*BPW-1:0]  Mem_Data,
  input  logic              Mem_MFC,
  output logic              Cpu_Hold,
  output logic              Done,
  output logic              Error,
  output logic [ADDR_W:0]   Byte_Count
);

  localparam int TW = $clog2(MFC_TIMEOUT) + 1;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   addr_q;
  logic [ADDR_W:0]   cnt_q;
  logic [TW-1:0]     timer_q;
  logic              last_seen_q;
  logic              start_ok;
  logic              accept;
  logic              collect_acc;
  logic              fits;
  logic              word_full;
`ifdef PRELOAD_CHECKSUM_EN
  logic [7:0]        sum_q;
`endif

  assign start_ok    = Start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERROR);
  assign accept      = In_Valid && In_Ready;
  assign collect_acc = accept && (state_q == ST_COLLECT);
  // addr_q carries one spare bit so an address past the RAM can never alias back into range.
  assign fits        = (32'(addr_q) + 32'(BPW - 1)) < 32'(BASE_ADDR + DEPTH);

  assign Mem_RW     = 1'b0;
  assign Mem_Type   = bpw_to_type(BPW);
  assign Mem_Addr   = addr_q[ADDR_W-1:0];
  assign Byte_Count = cnt_q;

  preload_word_asm #(.BPW(BPW)) u_asm (
    .clk       (Clk),
    .rst       (Clr),
    .clear     (start_ok),
    .next_word (state_q == ST_WRITE),
    .byte_vld  (collect_acc),
    .byte_dat  (In_Data),
    .byte_last (In_Last),
    .word_dat  (Mem_Data),
    .word_full (word_full)
  );

  always_ff @(posedge Clk) begin
    if (Clr) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    In_Ready = 1'b0;
    Mem_Mov  = 1'b0;
    Cpu_Hold = 1'b0;
    Done     = 1'b0;
    Error    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        In_Ready = 1'b1;
        Cpu_Hold = 1'b1;
        if (collect_acc && (word_full || In_Last)) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        Cpu_Hold = 1'b1;
        state_d  = fits ? ST_WAIT_MFC : ST_ERROR;
      end
      ST_WAIT_MFC: begin
        Mem_Mov  = 1'b1;
        Cpu_Hold = 1'b1;
        if (Mem_MFC) begin
`ifdef PRELOAD_CHECKSUM_EN
          state_d = last_seen_q ? ST_CHECK : ST_COLLECT;
`else
          state_d = last_seen_q ? ST_DONE : ST_COLLECT;
`endif
        end else if (timer_q == TW'(MFC_TIMEOUT - 1)) begin
          state_d = ST_ERROR;
        end
      end
`ifdef PRELOAD_CHECKSUM_EN
      ST_CHECK: begin
        In_Ready = 1'b1;
        Cpu_Hold = 1'b1;
        if (accept) state_d = (In_Data == sum_q) ? ST_DONE : ST_ERROR;
      end
`endif
      ST_DONE: begin
        Done = 1'b1;
        if (start_ok) state_d = ST_COLLECT;
      end
      ST_ERROR: begin
        Error    = 1'b1;
        Cpu_Hold = 1'b1;
        if (start_ok) state_d = ST_COLLECT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      addr_q      <= (ADDR_W+1)'(BASE_ADDR);
      cnt_q       <= '0;
      timer_q     <= '0;
      last_seen_q <= 1'b0;
    end else begin
      if (start_ok) begin
        addr_q      <= (ADDR_W+1)'(BASE_ADDR);
        cnt_q       <= '0;
        last_seen_q <= 1'b0;
      end
      if (collect_acc) begin
        cnt_q <= cnt_q + (ADDR_W+1)'(1);
        if (In_Last) last_seen_q <= 1'b1;
      end
      if (state_q == ST_WRITE)         timer_q <= '0;
      else if (state_q == ST_WAIT_MFC) timer_q <= timer_q + TW'(1);
      if (state_q == ST_WAIT_MFC && Mem_MFC) addr_q <= addr_q + (ADDR_W+1)'(BPW);
    end
  end

`ifdef PRELOAD_CHECKSUM_EN
  always_ff @(posedge Clk) begin
    if (Clr)              sum_q <= '0;
    else if (start_ok)    sum_q <= '0;
    else if (collect_acc) sum_q <= sum_q + In_Data;
  end
`endif

endmodule
